// File: rtl/ssd_counter_ndigit.sv
// -----------------------------------------------------------------------------
// ssd_counter_ndigit
//
// Multi-digit up/down counter with a multiplexed seven-segment display driver.
// The count advances by one every TICK_DIV enabled clock cycles. In hex mode the
// digits form one binary number. In BCD mode each digit counts 0..9 with
// carry and borrow between digits. A free-running scan counter steps through
// the digits and drives one active-low anode together with that digit's
// active-low segment pattern.
//
// Ports
//   clk       in   sole clock, rising edge
//   rstn      in   synchronous active-low reset
//   en        in   1 = prescaler runs and counting is enabled, 0 = both frozen
//   up        in   1 = count up, 0 = count down
//   dec_mode  in   1 = BCD (radix 10), 0 = hex (radix 16)
//   load      in   synchronous load strobe, overrides a coincident step
//   load_val  in   value to load, digit k at bits [4k+3:4k]
//   digits    out  registered count, digit 0 in the LSBs
//   wrap      out  one-cycle pulse while digits shows a wrapped value
//   an        out  active-low one-hot digit select
//   seg       out  active-low segments, seg[0]=a .. seg[6]=g
// -----------------------------------------------------------------------------
module ssd_counter_ndigit #(
    parameter int N_DIGITS = 8,
    parameter int TICK_DIV = 10_000_000,
    parameter int SCAN_DIV = 100_000
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic                  up,
    input  logic                  dec_mode,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] load_val,
    output logic [4*N_DIGITS-1:0] digits,
    output logic                  wrap,
    output logic [N_DIGITS-1:0]   an,
    output logic [6:0]            seg
);

    localparam int W  = 4 * N_DIGITS;
    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [PW-1:0]       PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0]       SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]       IDX_LAST   = IW'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] AN_ONE     = N_DIGITS'(1);
    localparam logic [6:0]          GLYPH_ZERO = 7'b1000000;

    // Active-low hex glyph, bit order gfedcba.
    function automatic logic [6:0] f_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'b1000000;
            4'h1:    g = 7'b1111001;
            4'h2:    g = 7'b0100100;
            4'h3:    g = 7'b0110000;
            4'h4:    g = 7'b0011001;
            4'h5:    g = 7'b0010010;
            4'h6:    g = 7'b0000010;
            4'h7:    g = 7'b1111000;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0010000;
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b0000011;
            4'hC:    g = 7'b1000110;
            4'hD:    g = 7'b0100001;
            4'hE:    g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PW-1:0]       r_presc;
    logic [W-1:0]        r_digits;
    logic                r_wrap;
    logic [SW-1:0]       r_scan;
    logic [IW-1:0]       r_idx;
    logic [N_DIGITS-1:0] r_an;
    logic [6:0]          r_seg;

    logic                w_step;
    logic [W-1:0]        w_hex_next;
    logic                w_hex_wrap;
    logic [W-1:0]        w_bcd_next;
    logic                w_bcd_wrap;
    logic [W-1:0]        w_load_clamped;
    logic [3:0]          w_sel_nib;

    assign w_step = en && (r_presc == PRESC_LAST);

    // Hex: the whole register is one binary number, wrapping naturally.
    assign w_hex_next = up ? (r_digits + W'(1)) : (r_digits - W'(1));
    assign w_hex_wrap = up ? (&r_digits) : ~(|r_digits);

    // BCD: ripple a carry (up) or borrow (down) from digit 0 upwards.
    // Nibbles above 9 are read as 9. Whatever is still propagating past
    // the top digit means the whole count was all-9 (up) or all-0 (down).
    // NOTE: every signal driven from always_comb gets a default before any
    // conditional assignment, so no path can leave it holding a value (latch).
    always_comb begin : bcd_step
        logic       v_chain;
        logic [3:0] v_nib;
        v_chain    = 1'b1;
        v_nib      = 4'd0;
        w_bcd_next = '0;
        for (int k = 0; k < N_DIGITS; k++) begin
            v_nib = (r_digits[4*k +: 4] > 4'd9) ? 4'd9 : r_digits[4*k +: 4];
            if (!v_chain) begin
                w_bcd_next[4*k +: 4] = v_nib;
            end else if (up) begin
                w_bcd_next[4*k +: 4] = (v_nib == 4'd9) ? 4'd0 : v_nib + 4'd1;
                v_chain              = (v_nib == 4'd9);
            end else begin
                w_bcd_next[4*k +: 4] = (v_nib == 4'd0) ? 4'd9 : v_nib - 4'd1;
                v_chain              = (v_nib == 4'd0);
            end
        end
        w_bcd_wrap = v_chain;
    end

    // Loaded nibbles above 9 are clamped only in BCD mode.
    always_comb begin
        w_load_clamped = load_val;
        if (dec_mode) begin
            for (int k = 0; k < N_DIGITS; k++) begin
                if (load_val[4*k +: 4] > 4'd9) begin
                    w_load_clamped[4*k +: 4] = 4'd9;
                end
            end
        end
    end

    // Nibble currently being displayed.
    always_comb begin
        w_sel_nib = 4'd0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (r_idx == IW'(k)) begin
                w_sel_nib = r_digits[4*k +: 4];
            end
        end
    end

    // ------------------------------------------------------------------
    // Prescaler and count
    // ------------------------------------------------------------------
    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_presc  <= '0;
            r_digits <= '0;
            r_wrap   <= 1'b0;
        end else if (load) begin
            // Load wins over a step landing in the same cycle.
            r_presc  <= '0;
            r_digits <= w_load_clamped;
            r_wrap   <= 1'b0;
        end else if (w_step) begin
            r_presc  <= '0;
            r_digits <= dec_mode ? w_bcd_next : w_hex_next;
            r_wrap   <= dec_mode ? w_bcd_wrap : w_hex_wrap;
        end else begin
            r_wrap <= 1'b0;
            if (en) begin
                r_presc <= r_presc + PW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Display scan: free-running, unaffected by en and load
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_scan <= '0;
            r_idx  <= '0;
            r_an   <= ~AN_ONE;
            r_seg  <= GLYPH_ZERO;
        end else begin
            if (r_scan == SCAN_LAST) begin
                r_scan <= '0;
                r_idx  <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
            end else begin
                r_scan <= r_scan + SW'(1);
            end
            // Outputs lag the index and digits by one cycle.
            r_an  <= ~(AN_ONE << r_idx);
            r_seg <= f_glyph(w_sel_nib);
        end
    end

    assign digits = r_digits;
    assign wrap   = r_wrap;
    assign an     = r_an;
    assign seg    = r_seg;

endmodule

// File: tb/tb_ssd_counter_ndigit.sv
// -----------------------------------------------------------------------------
// tb_ssd_counter_ndigit
//
// Self-checking bench for ssd_counter_ndigit with N_DIGITS=4, TICK_DIV=4,
// SCAN_DIV=2. A behavioural model holds the count as an integer and the
// display glyphs as lists of lit segments; every cycle the DUT outputs are
// compared against it. Directed scenarios add literal expectations, then a
// randomized phase exercises mixed load/step/reset/mode traffic.
// -----------------------------------------------------------------------------
module tb_ssd_counter_ndigit;

    localparam int N    = 4;
    localparam int TDIV = 4;
    localparam int SDIV = 2;
    localparam int W    = 4 * N;

    logic         clk;
    logic         rstn;
    logic         en;
    logic         up;
    logic         dec_mode;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] digits;
    logic         wrap;
    logic [N-1:0] an;
    logic [6:0]   seg;

    ssd_counter_ndigit #(
        .N_DIGITS (N),
        .TICK_DIV (TDIV),
        .SCAN_DIV (SDIV)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .en       (en),
        .up       (up),
        .dec_mode (dec_mode),
        .load     (load),
        .load_val (load_val),
        .digits   (digits),
        .wrap     (wrap),
        .an       (an),
        .seg      (seg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    // Lit segments of each hex glyph.
    string lit [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                        "acdefg", "abc", "abcdefg", "abcdfg", "abcefg",
                        "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    function automatic logic [6:0] glyph(input int v);
        logic [6:0] g;
        string      s;
        g = 7'h7F;
        s = lit[v];
        for (int i = 0; i < s.len(); i++) g[int'(s[i]) - 97] = 1'b0;
        return g;
    endfunction

    int           m_presc = 0;
    int           m_scan  = 0;
    int           m_idx   = 0;
    logic [W-1:0] m_digits = '0;
    logic         m_wrap   = 1'b0;
    logic [N-1:0] m_an     = 4'b1110;
    logic [6:0]   m_seg    = 7'b1000000;

    // Step as decimal or binary arithmetic on the whole number.
    function automatic logic [W-1:0] count_step(input logic [W-1:0] d, input logic cnt_up,
                                                input logic dec, output logic wr);
        longint v, lim, p;
        logic [W-1:0] r;
        int nib;
        r = '0;
        if (dec) begin
            v = 0; p = 1;
            for (int k = 0; k < N; k++) begin
                nib = int'(d[4*k +: 4]);
                if (nib > 9) nib = 9;
                v += longint'(nib) * p;
                p *= 10;
            end
            lim = p;
        end else begin
            v   = longint'(d);
            lim = longint'(1) << W;
        end
        if (cnt_up) begin
            wr = (v == lim - 1);
            v  = (v + 1) % lim;
        end else begin
            wr = (v == 0);
            v  = (v + lim - 1) % lim;
        end
        if (dec) begin
            for (int k = 0; k < N; k++) begin
                r[4*k +: 4] = 4'(v % 10);
                v /= 10;
            end
        end else begin
            r = W'(v);
        end
        return r;
    endfunction

    task automatic model_update();
        logic [W-1:0] old_d;
        int           old_idx;
        logic         wr;
        old_d   = m_digits;
        old_idx = m_idx;
        if (!rstn) begin
            m_presc  = 0;
            m_scan   = 0;
            m_idx    = 0;
            m_digits = '0;
            m_wrap   = 1'b0;
            m_an     = '1;
            m_an[0]  = 1'b0;
            m_seg    = glyph(0);
        end else begin
            m_an          = '1;
            m_an[old_idx] = 1'b0;
            m_seg         = glyph(int'(old_d[4*old_idx +: 4]));
            if (m_scan == SDIV - 1) begin
                m_scan = 0;
                m_idx  = (m_idx + 1) % N;
            end else begin
                m_scan++;
            end
            m_wrap = 1'b0;
            if (load) begin
                m_presc = 0;
                for (int k = 0; k < N; k++) begin
                    m_digits[4*k +: 4] = (dec_mode && load_val[4*k +: 4] > 9) ? 4'd9 : load_val[4*k +: 4];
                end
            end else if (en && m_presc == TDIV - 1) begin
                m_presc  = 0;
                m_digits = count_step(old_d, up, dec_mode, wr);
                m_wrap   = wr;
            end else if (en) begin
                m_presc++;
            end
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            model_update();
            check("digits", digits, m_digits);
            check("wrap", wrap, m_wrap);
            check("an", an, m_an);
            check("seg", seg, m_seg);
        end
    endtask

    task automatic do_load(input logic [W-1:0] v);
        load     = 1'b1;
        load_val = v;
        tick(1);
        load     = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    logic [N-1:0] exp_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0]   exp_seg [4] = '{7'b1111001, 7'b0100100, 7'b0011001, 7'b0000000};

    initial begin
        int  budget;
        rstn = 1'b0; en = 1'b0; up = 1'b1; dec_mode = 1'b0;
        load = 1'b0; load_val = '0;

        // Reset, with load and en active to confirm reset overrides them.
        load = 1'b1; load_val = 16'h5555; en = 1'b1;
        tick(2);
        load = 1'b0;
        check("rst_digits", digits, 16'h0000);
        check("rst_wrap", wrap, 1'b0);
        check("rst_an", an, 4'b1110);
        check("rst_seg", seg, 7'b1000000);

        // Hex up, then hold with en low mid-count.
        rstn = 1'b1; en = 1'b1; up = 1'b1; dec_mode = 1'b0;
        tick(4);
        check("hex_up1", digits, 16'h0001);
        tick(4);
        check("hex_up2", digits, 16'h0002);
        tick(2);
        en = 1'b0;
        tick(5);
        check("hold_digits", digits, 16'h0002);
        en = 1'b1;
        tick(1);
        check("hold_presc", digits, 16'h0002);
        tick(1);
        check("resume_step", digits, 16'h0003);

        // Hex wrap both ways.
        do_load(16'hFFFF);
        tick(3);
        check("hex_pre_wrap", digits, 16'hFFFF);
        tick(1);
        check("hex_wrap_up", digits, 16'h0000);
        check("hex_wrap_up_pulse", wrap, 1'b1);
        tick(1);
        check("hex_wrap_up_end", wrap, 1'b0);
        up = 1'b0;
        do_load(16'h0000);
        tick(4);
        check("hex_wrap_dn", digits, 16'hFFFF);
        check("hex_wrap_dn_pulse", wrap, 1'b1);
        tick(1);
        check("hex_wrap_dn_end", wrap, 1'b0);

        // BCD carries, borrow, wrap and load clamp.
        dec_mode = 1'b1; up = 1'b1;
        do_load(16'h0999);
        tick(4);
        check("bcd_carry", digits, 16'h1000);
        check("bcd_carry_wrap", wrap, 1'b0);
        do_load(16'h9999);
        tick(4);
        check("bcd_wrap", digits, 16'h0000);
        check("bcd_wrap_pulse", wrap, 1'b1);
        up = 1'b0;
        do_load(16'h1000);
        tick(4);
        check("bcd_borrow", digits, 16'h0999);
        do_load(16'h00AF);
        check("bcd_clamp", digits, 16'h0099);

        // Load beats a coincident (wrapping) step; reset discards a step.
        dec_mode = 1'b0; up = 1'b1;
        do_load(16'hFFFF);
        tick(3);
        do_load(16'h1234);
        check("prio_load", digits, 16'h1234);
        check("prio_wrap", wrap, 1'b0);
        tick(3);
        check("prio_hold", digits, 16'h1234);
        tick(1);
        check("prio_next", digits, 16'h1235);
        tick(3);
        rstn = 1'b0;
        tick(1);
        check("rst_step", digits, 16'h0000);
        rstn = 1'b1;

        // Scan sequence with a frozen count.
        en = 1'b0;
        do_load(16'h8421);
        budget = 0;
        while (an !== 4'b0111 && budget < 20) begin
            tick(1);
            budget++;
        end
        check("scan_sync", an, 4'b0111);
        budget = 0;
        while (an === 4'b0111 && budget < 4) begin
            tick(1);
            budget++;
        end
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) begin
                for (int c = 0; c < 2; c++) begin
                    check("scan_an", an, exp_an[k]);
                    check("scan_seg", seg, exp_seg[k]);
                    tick(1);
                end
            end
        end

        // Randomized traffic against the model.
        en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            rstn = ($urandom_range(0, 299) != 0);
            en   = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 31) == 0) up = ~up;
            if ($urandom_range(0, 63) == 0) dec_mode = ~dec_mode;
            load = ($urandom_range(0, 23) == 0);
            case ($urandom_range(0, 5))
                0:       load_val = 16'hFFFF;
                1:       load_val = 16'h9999;
                2:       load_val = 16'h0000;
                3:       load_val = 16'h0999;
                4:       load_val = 16'h9998;
                default: load_val = W'($urandom);
            endcase
            tick(1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ssd_counter_ndigit.md
SSD_COUNTER_NDIGIT -- requirements
Module: ssd_counter_ndigit

Interface
REQ-001 SHALL have parameter N_DIGITS, default 8: number of 4-bit digits, legal range 1..8.
REQ-002 SHALL have parameter TICK_DIV, default 10_000_000: clk cycles per count step, minimum 2.
REQ-003 SHALL have parameter SCAN_DIV, default 100_000: clk cycles per display digit slot, minimum 2.
REQ-004 SHALL have port clk  in  1: sole clock, all logic on its rising edge.
REQ-005 SHALL have port rstn  in  1: reset, synchronous and active-low.
REQ-006 SHALL have port en  in  1: 1 enables prescaler and counting; 0 freezes both.
REQ-007 SHALL have port up  in  1: 1 counts up, 0 counts down.
REQ-008 SHALL have port dec_mode  in  1: 1 selects BCD (radix 10), 0 selects hex (radix 16).
REQ-009 SHALL have port load  in  1: synchronous load strobe.
REQ-010 SHALL have port load_val  in  4*N_DIGITS: value to load, digit k at bits [4k+3:4k].
REQ-011 SHALL have port digits  out  4*N_DIGITS: registered count, digit 0 in the LSBs.
REQ-012 SHALL have port wrap  out  1: one-cycle pulse on overflow or underflow.
REQ-013 SHALL have port an  out  N_DIGITS: active-low one-hot digit select.
REQ-014 SHALL have port seg  out  7: active-low segments, seg[0]=a through seg[6]=g.

Function
REQ-015 Prescaler SHALL count 0..TICK_DIV-1 while en=1 and hold its value while en=0.
REQ-016 An internal step SHALL fire in a cycle where en=1 and the prescaler equals TICK_DIV-1; the prescaler then returns to 0 on that edge.
REQ-017 On step, digits SHALL update on the same edge, so the new value is visible the cycle after the prescaler reaches TICK_DIV-1.
REQ-018 Hex mode SHALL update digits as one binary value, incrementing or decrementing modulo 16^N_DIGITS.
REQ-019 BCD mode SHALL update per digit. Up: 9->0 with carry into the next digit. Down: 0->9 with borrow from the next digit.
REQ-020 In BCD mode, any nibble >9 SHALL be treated as 9 when computing a step.
REQ-021 wrap SHALL be 1 for exactly the one cycle in which digits shows the wrapped value. Wrap cases: all-max -> all-zero when counting up; all-zero -> all-max when counting down. All-max is 0xF per digit in hex mode and 0x9 per digit in BCD mode.
REQ-022 A load SHALL set digits <= load_val and the prescaler <= 0 on the same edge.
REQ-023 In a load with dec_mode=1, each nibble >9 SHALL be clamped to 9.
REQ-024 load SHALL take priority over a coincident step. No count occurs and wrap stays 0 in that cycle.
REQ-025 load SHALL act regardless of en.
REQ-026 A change of up or dec_mode SHALL take effect at the next step. Changing them SHALL NOT alter digits by itself.
REQ-027 Scan counter SHALL count 0..SCAN_DIV-1 continuously, independent of en and load.
REQ-028 At terminal count the scan counter SHALL advance the digit index 0->1->...->N_DIGITS-1->0.
REQ-029 an and seg SHALL be registered and reflect the current index and digits with one cycle of latency.
REQ-030 an[idx] SHALL be 0 and all other an bits SHALL be 1.
REQ-031 seg SHALL be the hex glyph 0-F of the selected nibble, active-low, in both modes.
REQ-032 Glyph encodings include 0=7'b1000000, 1=7'b1111001 and 8=7'b0000000.

Reset
REQ-033 While rstn=0 at a clock edge, the block SHALL set prescaler, scan counter and index to 0.
REQ-034 While rstn=0 at a clock edge, the block SHALL set digits=0, wrap=0, an=all ones except an[0]=0, and seg=7'b1000000.
REQ-035 Reset SHALL override load and en.
REQ-036 Reset asserted mid-step SHALL discard the pending step.
REQ-037 Reset SHALL have no effect between clock edges.

Verification
All scenarios use N_DIGITS=4, TICK_DIV=4 and SCAN_DIV=2.
REQ-038 Reset: hold rstn=0 for 2 cycles -> digits=0x0000, wrap=0, an=4'b1110, seg=7'b1000000.
REQ-039 Hex up: release reset with en=1, up=1, dec_mode=0 -> digits=0x0001 after 4 cycles and 0x0002 after 8 cycles. Drop en for 5 cycles -> digits and prescaler hold.
REQ-040 Hex wrap: load 0xFFFF, then up step -> digits=0x0000 with wrap=1 for one cycle. Load 0x0000, then down step -> 0xFFFF with wrap=1.
REQ-041 BCD: with dec_mode=1, 0x0999 up -> 0x1000 with wrap=0. 0x9999 up -> 0x0000 with wrap=1. 0x1000 down -> 0x0999. Load 0x00AF -> digits=0x0099.
REQ-042 Priority: assert load=1 (load_val=0x1234) in the step cycle -> digits=0x1234, wrap=0, next step 4 cycles later gives 0x1235. Assert rstn=0 in a step cycle -> digits=0x0000.
REQ-043 Scan: digits=0x8421 -> an cycles 1110, 1101, 1011, 0111 every 2 cycles. seg shows 1, 2, 4, 8 glyphs in turn, then repeats.
